// File: rtl/instruction_memory_if.sv
// Instruction fetch bus between a fetch unit and the instruction memory.
//
// Signals:
//   pc               byte address of the instruction to fetch (master -> slave)
//   instruction_code instruction word at pc, combinational  (slave -> master)
//
// Modports:
//   master  fetch side: drives pc, receives instruction_code
//   slave   memory side: receives pc, drives instruction_code
interface instruction_memory_if;
  logic [31:0] pc;
  logic [31:0] instruction_code;

  modport master (output pc, input instruction_code);
  modport slave  (input pc, output instruction_code);
endinterface

// File: rtl/instruction_memory.sv
// Read-only instruction memory with a built-in default program.
//
// The word array is (re)loaded with the default program on every rising
// clock edge while rst is low. Reads are purely combinational, so a pc
// change shows up in instruction_code within the same cycle.
//
// Parameters:
//   DEPTH     number of 32-bit instruction words stored
//   NOP_WORD  word returned for out-of-range addresses and during reset
//
// Ports:
//   clk  clock, all state changes on the rising edge
//   rst  synchronous active-low reset (0 = reset)
//   bus  instruction_memory_if.slave: pc in, instruction_code out
module instruction_memory #(
  parameter int          DEPTH    = 64,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst,
  instruction_memory_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] mem [DEPTH];

  logic [29:0] word_index;
  logic        in_range;
  logic [1:0]  unused_byte_offset;

  // Default program image; every word past the last instruction is a NOP.
  function automatic logic [31:0] default_word(input int idx);
    logic [31:0] word;
    case (idx)
      0:       word = 32'h0050_0093;  // addi x1,x0,5
      1:       word = 32'h0030_0113;  // addi x2,x0,3
      2:       word = 32'h0020_81B3;  // add  x3,x1,x2
      3:       word = 32'h4020_8233;  // sub  x4,x1,x2
      4:       word = 32'h0020_F2B3;  // and  x5,x1,x2
      5:       word = 32'h0020_E333;  // or   x6,x1,x2
      6:       word = 32'h0030_2023;  // sw   x3,0(x0)
      7:       word = 32'h0000_2383;  // lw   x7,0(x0)
      8:       word = 32'h0013_8433;  // add  x8,x7,x1
      9:       word = 32'h0010_8463;  // beq  x1,x1,+8
      10:      word = 32'h0010_0493;  // addi x9,x0,1 (skipped by the branch)
      11:      word = 32'h0020_0513;  // addi x10,x0,2
      12:      word = 32'h0000_006F;  // jal  x0,0 (self-loop)
      default: word = NOP_WORD;
    endcase
    return word;
  endfunction

  // The array only changes during reset, when the whole image is reloaded;
  // otherwise it holds its contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= default_word(i);
      end
    end
  end

  // Byte offset is ignored: a misaligned pc returns the containing word.
  assign word_index         = bus.pc[31:2];
  assign unused_byte_offset = bus.pc[1:0];

  // Full 30-bit compare so large addresses never alias back into the array.
  assign in_range = (word_index < 30'(DEPTH));

  // rst gates the output combinationally, so the NOP appears immediately
  // when reset is asserted and the array value as soon as it is released.
  always_comb begin
    bus.instruction_code = NOP_WORD;
    if (rst && in_range) begin
      bus.instruction_code = mem[word_index[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking testbench for instruction_memory.
//
// Directed steps cover reset, the full program walk, misaligned and
// out-of-range addresses and a mid-operation reset; a randomized phase
// then compares the DUT against a reference model built from the program
// listing.
module tb_instruction_memory;

  localparam int          DEPTH    = 64;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  instruction_memory_if bus ();

  instruction_memory #(
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP_WORD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program listing, indexed by word address.
  logic [31:0] program_words [13] = '{
    32'h0050_0093, 32'h0030_0113, 32'h0020_81B3, 32'h4020_8233,
    32'h0020_F2B3, 32'h0020_E333, 32'h0030_2023, 32'h0000_2383,
    32'h0013_8433, 32'h0010_8463, 32'h0010_0493, 32'h0020_0513,
    32'h0000_006F
  };

  // Reference model: what a fetch at byte address pc must return.
  function automatic logic [31:0] model_word(input logic [31:0] pc, input logic rst_val);
    longint unsigned idx;
    idx = longint'(pc) / 4;
    if (rst_val == 1'b0) return NOP_WORD;
    if (idx >= DEPTH) return NOP_WORD;
    if (idx >= 13) return NOP_WORD;
    return program_words[int'(idx)];
  endfunction

  // Drive new inputs just after a rising edge.
  task automatic apply_stimulus(input logic [31:0] pc_val, input logic rst_val);
    @(posedge clk);
    #1;
    bus.pc = pc_val;
    rst    = rst_val;
  endtask

  // Sample mid-cycle, well away from the active edge.
  task automatic check_output(input string tag, input logic [31:0] expected);
    #3;
    checks++;
    assert (bus.instruction_code === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h (pc=%h rst=%b)",
             tag, bus.instruction_code, expected, bus.pc, rst);
    end
  endtask

  initial begin
    logic [31:0] pc_val;
    logic        rst_val;

    checks = 0;
    errors = 0;
    rst    = 1'b0;
    bus.pc = 32'h0;

    // Output is NOP while reset is low, even before the array is loaded.
    check_output("reset_before_edge", NOP_WORD);
    @(posedge clk);
    #1;
    check_output("reset_cycle1", NOP_WORD);

    // Release reset after two reset edges; pc=0 visible in the same cycle.
    apply_stimulus(32'h0, 1'b1);
    check_output("first_fetch", 32'h0050_0093);

    // Walk the program one word per cycle.
    for (int a = 0; a <= 32'h30; a += 4) begin
      apply_stimulus(32'(a), 1'b1);
      check_output($sformatf("walk_%02h", a), model_word(32'(a), 1'b1));
    end
    apply_stimulus(32'h24, 1'b1);
    check_output("beq_word", 32'h0010_8463);
    apply_stimulus(32'h30, 1'b1);
    check_output("jal_word", 32'h0000_006F);

    // Misaligned addresses return the containing word.
    apply_stimulus(32'h0A, 1'b1);
    check_output("misaligned_0a", 32'h0020_81B3);
    apply_stimulus(32'h2F, 1'b1);
    check_output("misaligned_2f", 32'h0020_0513);

    // Filler and out-of-range addresses.
    apply_stimulus(32'h34, 1'b1);
    check_output("filler_34", NOP_WORD);
    apply_stimulus(32'hFC, 1'b1);
    check_output("last_word_fc", NOP_WORD);
    apply_stimulus(32'h100, 1'b1);
    check_output("oor_depth", NOP_WORD);
    apply_stimulus(32'hFFFF_FFFC, 1'b1);
    check_output("oor_top", NOP_WORD);
    apply_stimulus(32'h4000_0000, 1'b1);
    check_output("oor_alias", NOP_WORD);

    // Mid-operation reset: NOP while low, stored word again once released.
    apply_stimulus(32'h28, 1'b1);
    check_output("pre_reset_28", 32'h0010_0493);
    apply_stimulus(32'h28, 1'b0);
    check_output("during_reset_28", NOP_WORD);
    apply_stimulus(32'h28, 1'b1);
    check_output("post_reset_28", 32'h0010_0493);

    // Randomized fetches with occasional reset pulses.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) pc_val = $urandom;
      else                           pc_val = 32'($urandom_range(0, 32'h11F));
      rst_val = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
      apply_stimulus(pc_val, rst_val);
      check_output($sformatf("random_%0d", n), model_word(pc_val, rst_val));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
